// File: rtl/fifo_burst_reader.sv
// Burst read engine: drains N words from a FIFO read port (1-cycle read latency)
// and re-presents them as a valid/ready stream through a 2-entry skid buffer.
module fifo_burst_reader #(
   parameter int DATA_WIDTH  = 64,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [COUNT_WIDTH-1:0] num_words,
   output logic                   busy,
   output logic                   done,
   output logic                   s_read_req,
   input  logic                   s_read_ready,
   input  logic [DATA_WIDTH-1:0]  s_read_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [DATA_WIDTH-1:0]  m_data
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

   state_e                 state_q, state_d;
   logic [COUNT_WIDTH-1:0] issue_left_q, issue_left_d;
   logic [COUNT_WIDTH-1:0] deliver_left_q, deliver_left_d;
   logic                   inflight_q;
   logic [1:0]             occ_q, occ_d;
   logic                   wr_ptr_q, rd_ptr_q;
   logic [DATA_WIDTH-1:0]  buf_q [2];

   logic       pop;
   logic       accept;
   logic [2:0] pending;

   assign pop     = m_valid && m_ready;
   assign accept  = s_read_req && s_read_ready;
   // Buffered words plus the one in flight, after this cycle's pop.
   assign pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = (num_words == '0) ? S_DONE : S_ISSUE;
         S_ISSUE: if (accept && issue_left_q == COUNT_WIDTH'(1)) state_d = S_DRAIN;
         S_DRAIN: if (pop && deliver_left_q == COUNT_WIDTH'(1)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      busy       = 1'b0;
      done       = 1'b0;
      s_read_req = 1'b0;
      m_valid    = 1'b0;
      m_data     = '0;
      busy       = (state_q != S_IDLE);
      done       = (state_q == S_DONE);
      m_valid    = (occ_q != 2'd0);
      s_read_req = (state_q == S_ISSUE) && (issue_left_q != '0) && (pending < 3'd2);
      if (m_valid) m_data = buf_q[rd_ptr_q];
   end

   always_comb begin
      issue_left_d   = issue_left_q;
      deliver_left_d = deliver_left_q;
      occ_d          = pending[1:0];
      if (state_q == S_IDLE && start) begin
         issue_left_d   = num_words;
         deliver_left_d = num_words;
      end else begin
         if (accept) issue_left_d   = issue_left_q - COUNT_WIDTH'(1);
         if (pop)    deliver_left_d = deliver_left_q - COUNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         issue_left_q   <= '0;
         deliver_left_q <= '0;
         inflight_q     <= 1'b0;
         occ_q          <= 2'd0;
         wr_ptr_q       <= 1'b0;
         rd_ptr_q       <= 1'b0;
      end else begin
         issue_left_q   <= issue_left_d;
         deliver_left_q <= deliver_left_d;
         inflight_q     <= accept;
         occ_q          <= occ_d;
         if (inflight_q) wr_ptr_q <= ~wr_ptr_q;
         if (pop)        rd_ptr_q <= ~rd_ptr_q;
      end
   end

   // NOTE: buffer storage is not reset; occupancy gates m_data, so stale contents never escape.
   always_ff @(posedge clk) begin
      if (inflight_q) buf_q[wr_ptr_q] <= s_read_data;
   end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader: FIFO model with 1-cycle read latency,
// expected-word queue filled at preload time and drained on each stream handshake.
module tb_fifo_burst_reader;
   localparam int DW = 64;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [CW-1:0] num_words = '0;
   logic          busy, done, s_read_req, m_valid;
   logic          s_read_ready = 1'b0;
   logic [DW-1:0] s_read_data = '0;
   logic          m_ready = 1'b0;
   logic [DW-1:0] m_data;

   fifo_burst_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .start(start), .num_words(num_words),
      .busy(busy), .done(done), .s_read_req(s_read_req), .s_read_ready(s_read_ready),
      .s_read_data(s_read_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_pass = 0;
   int            cyc = 0;
   logic [DW-1:0] fifo_q[$];
   logic [DW-1:0] exp_q[$];
   logic          acc_pending = 1'b0;
   logic [DW-1:0] next_data = '0;
   int            outstanding = 0;
   int            req_viol, stall_err, leak_err, done_cnt, req_cnt, busy_cnt, words_rx;
   int            first_req, done_cyc, last_busy;
   int            hs_cyc[$];
   logic          prev_stall = 1'b0;
   logic [DW-1:0] held_data = '0;
   bit            bp_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

   task automatic clear_mon();
      req_viol = 0; stall_err = 0; leak_err = 0; done_cnt = 0; req_cnt = 0;
      busy_cnt = 0; words_rx = 0; first_req = -1; done_cyc = -1; last_busy = -1;
      hs_cyc.delete();
      prev_stall = 1'b0;
   endtask

   task automatic reset_model();
      fifo_q.delete();
      exp_q.delete();
      acc_pending = 1'b0;
      outstanding = 0;
   endtask

   // One clock: drive inputs just after posedge, observe and score at negedge.
   task automatic tick(input logic st, input logic [CW-1:0] nw, input logic mr, input logic starve);
      logic          pop_now, acc_now;
      logic [DW-1:0] e;
      @(posedge clk);
      cyc++;
      #1;
      start        = st;
      num_words    = nw;
      m_ready      = mr;
      s_read_ready = !starve && (fifo_q.size() != 0);
      if (acc_pending) begin
         s_read_data = next_data;
         acc_pending = 1'b0;
      end
      @(negedge clk);
      pop_now = m_valid && m_ready;
      acc_now = s_read_req && s_read_ready;
      if (prev_stall && (!m_valid || m_data !== held_data)) stall_err++;
      prev_stall = m_valid && !m_ready;
      held_data  = m_data;
      if (m_valid && !busy) leak_err++;
      if (!m_valid && m_data !== '0) leak_err++;
      if (s_read_req) begin
         req_cnt++;
         if (first_req < 0) first_req = cyc;
         if (outstanding - int'(pop_now) >= 2) req_viol++;
      end
      if (busy) begin
         busy_cnt++;
         last_busy = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (pop_now) begin
         hs_cyc.push_back(cyc);
         words_rx++;
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL sb_extra_word: got %0h, expected no word", m_data);
         end else begin
            e = exp_q.pop_front();
            if (m_data !== e) $display("FAIL sb_data: got %0h expected %0h", m_data, e);
            else n_pass++;
         end
      end
      if (acc_now && fifo_q.size() != 0) begin
         next_data   = fifo_q.pop_front();
         acc_pending = 1'b1;
      end
      outstanding += int'(acc_now) - int'(pop_now);
   endtask

   task automatic preload(input int n, input int n_exp, input bit seq, input logic [DW-1:0] base);
      logic [DW-1:0] w;
      for (int i = 0; i < n; i++) begin
         w = seq ? base + DW'(i) : {$urandom, $urandom};
         fifo_q.push_back(w);
         if (i < n_exp) exp_q.push_back(w);
      end
   endtask

   // Start a burst at relative cycle 0 and run until done plus a few idle cycles.
   task automatic run_burst(input int nw, input bit bp, input int st_lo, input int st_hi,
                            input int extra_at, input int extra_nw, output int c0);
      int  rel;
      bit  mr;
      clear_mon();
      tick(1'b1, CW'(nw), 1'b1, 1'b0);
      c0  = cyc;
      rel = 1;
      while (done_cnt == 0 && rel < 300) begin
         mr = bp ? bp_pat[rel % 4] : 1'b1;
         tick(rel == extra_at, (rel == extra_at) ? CW'(extra_nw) : '0, mr,
              (rel >= st_lo) && (rel <= st_hi));
         rel++;
      end
      n_checks++;
      if (done_cnt == 0) $display("FAIL burst_timeout: got no done after %0d cycles, expected done", rel);
      else n_pass++;
      for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b1, 1'b0);
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
      n_checks++; if (s_read_req !== 1'b0) $display("FAIL reset_req: got %b expected 0", s_read_req); else n_pass++;
      n_checks++; if (m_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", m_valid); else n_pass++;
      n_checks++; if (m_data !== '0) $display("FAIL reset_data: got %0h expected 0", m_data); else n_pass++;
      reset = 1'b1;
      tick(1'b0, '0, 1'b1, 1'b0);
   endtask

   task automatic test_basic();
      int c0, f_hs, l_hs;
      preload(8, 8, 1'b1, 64'h10);
      run_burst(8, 1'b0, -1, -1, -1, 0, c0);
      f_hs = (hs_cyc.size() != 0) ? hs_cyc[0] - c0 : -1;
      l_hs = (hs_cyc.size() != 0) ? hs_cyc[hs_cyc.size()-1] - c0 : -1;
      n_checks++; if (first_req - c0 !== 1) $display("FAIL basic_first_req: got cycle %0d expected 1", first_req - c0); else n_pass++;
      n_checks++; if (f_hs !== 3) $display("FAIL basic_first_valid: got cycle %0d expected 3", f_hs); else n_pass++;
      n_checks++; if (l_hs !== 10) $display("FAIL basic_last_valid: got cycle %0d expected 10", l_hs); else n_pass++;
      n_checks++; if (words_rx !== 8) $display("FAIL basic_words: got %0d expected 8", words_rx); else n_pass++;
      n_checks++; if (done_cyc - c0 !== 11 || done_cnt !== 1) $display("FAIL basic_done: got cycle %0d count %0d expected cycle 11 count 1", done_cyc - c0, done_cnt); else n_pass++;
      n_checks++; if (last_busy - c0 !== 11) $display("FAIL basic_busy_end: got last busy %0d expected 11", last_busy - c0); else n_pass++;
      n_checks++; if (leak_err !== 0) $display("FAIL basic_leak: got %0d expected 0", leak_err); else n_pass++;
   endtask

   task automatic test_backpressure();
      int c0;
      preload(6, 6, 1'b0, '0);
      run_burst(6, 1'b1, -1, -1, -1, 0, c0);
      n_checks++; if (words_rx !== 6) $display("FAIL bp_words: got %0d expected 6", words_rx); else n_pass++;
      n_checks++; if (exp_q.size() !== 0) $display("FAIL bp_missing: got %0d left expected 0", exp_q.size()); else n_pass++;
      n_checks++; if (stall_err !== 0) $display("FAIL bp_stable: got %0d unstable cycles expected 0", stall_err); else n_pass++;
      n_checks++; if (req_viol !== 0) $display("FAIL bp_req_full: got %0d overissue cycles expected 0", req_viol); else n_pass++;
      n_checks++; if (done_cnt !== 1) $display("FAIL bp_done: got %0d pulses expected 1", done_cnt); else n_pass++;
      n_checks++; if (fifo_q.size() !== 0) $display("FAIL bp_fifo_left: got %0d expected 0", fifo_q.size()); else n_pass++;
   endtask

   task automatic test_starvation();
      int c0;
      int exp_rel[4] = '{3, 12, 13, 14};
      preload(4, 4, 1'b0, '0);
      run_burst(4, 1'b0, 2, 9, -1, 0, c0);
      n_checks++; if (words_rx !== 4) $display("FAIL starve_words: got %0d expected 4", words_rx); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (i >= hs_cyc.size()) $display("FAIL starve_hs%0d: got none expected cycle %0d", i, exp_rel[i]);
         else if (hs_cyc[i] - c0 !== exp_rel[i]) $display("FAIL starve_hs%0d: got cycle %0d expected %0d", i, hs_cyc[i] - c0, exp_rel[i]);
         else n_pass++;
      end
      n_checks++; if (done_cyc - c0 !== 15 || done_cnt !== 1) $display("FAIL starve_done: got cycle %0d count %0d expected cycle 15 count 1", done_cyc - c0, done_cnt); else n_pass++;
   endtask

   task automatic test_zero_length();
      int c0;
      run_burst(0, 1'b0, -1, -1, -1, 0, c0);
      n_checks++; if (req_cnt !== 0) $display("FAIL zero_req: got %0d requests expected 0", req_cnt); else n_pass++;
      n_checks++; if (done_cyc - c0 !== 1 || done_cnt !== 1) $display("FAIL zero_done: got cycle %0d count %0d expected cycle 1 count 1", done_cyc - c0, done_cnt); else n_pass++;
      n_checks++; if (busy_cnt !== 1) $display("FAIL zero_busy: got %0d busy cycles expected 1", busy_cnt); else n_pass++;
      n_checks++; if (words_rx !== 0) $display("FAIL zero_words: got %0d expected 0", words_rx); else n_pass++;
   endtask

   task automatic test_start_while_busy();
      int c0;
      preload(8, 5, 1'b0, '0);
      run_burst(5, 1'b0, -1, -1, 2, 3, c0);
      n_checks++; if (words_rx !== 5) $display("FAIL busy_start_words: got %0d expected 5", words_rx); else n_pass++;
      n_checks++; if (done_cnt !== 1) $display("FAIL busy_start_done: got %0d pulses expected 1", done_cnt); else n_pass++;
      n_checks++; if (fifo_q.size() !== 3) $display("FAIL busy_start_reads: got %0d left in fifo expected 3", fifo_q.size()); else n_pass++;
      fifo_q.delete();
   endtask

   task automatic test_async_reset();
      int c0, budget;
      clear_mon();
      preload(8, 8, 1'b0, '0);
      tick(1'b1, CW'(8), 1'b1, 1'b0);
      budget = 0;
      while (words_rx < 3 && budget < 50) begin
         tick(1'b0, '0, 1'b1, 1'b0);
         budget++;
      end
      n_checks++; if (words_rx !== 3) $display("FAIL arst_reach_word3: got %0d words expected 3", words_rx); else n_pass++;
      #2;
      reset = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL arst_busy: got %b expected 0", busy); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL arst_done: got %b expected 0", done); else n_pass++;
      n_checks++; if (s_read_req !== 1'b0) $display("FAIL arst_req: got %b expected 0", s_read_req); else n_pass++;
      n_checks++; if (m_valid !== 1'b0) $display("FAIL arst_valid: got %b expected 0", m_valid); else n_pass++;
      n_checks++; if (m_data !== '0) $display("FAIL arst_data: got %0h expected 0", m_data); else n_pass++;
      reset_model();
      clear_mon();
      tick(1'b0, '0, 1'b1, 1'b0);
      tick(1'b0, '0, 1'b1, 1'b0);
      reset = 1'b1;
      tick(1'b0, '0, 1'b1, 1'b0);
      n_checks++; if (done_cnt !== 0 || busy !== 1'b0) $display("FAIL arst_idle: got done %0d busy %b expected 0 0", done_cnt, busy); else n_pass++;
      reset_model();
      preload(2, 2, 1'b1, 64'hA0);
      run_burst(2, 1'b0, -1, -1, -1, 0, c0);
      n_checks++; if (words_rx !== 2) $display("FAIL arst_after_words: got %0d expected 2", words_rx); else n_pass++;
      n_checks++; if (done_cyc - c0 !== 5 || done_cnt !== 1) $display("FAIL arst_after_done: got cycle %0d count %0d expected cycle 5 count 1", done_cyc - c0, done_cnt); else n_pass++;
   endtask

   initial begin
      clear_mon();
      test_reset();
      test_basic();
      test_backpressure();
      test_starvation();
      test_zero_length();
      test_start_while_busy();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
